// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared constants (XLEN, INSTR_BYTES, NOP_INSTR) and clamp_take(take, avail) for the fetch queue
package fetch_queue_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0;
  function automatic int clamp_take(input int take, input int avail);
    return take > avail ? avail : take;
  endfunction
endpackage

// File: rtl/fq_ring_ram.sv
// fq_ring_ram: DEPTH x W register array; clk, WR write ports (we/waddr/wdata), RD combinational read ports (raddr -> rdata)
module fq_ring_ram #(
  parameter int DEPTH = 8,
  parameter int WR = 2,
  parameter int RD = 2,
  parameter int W = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic [WR-1:0]    we,
  input  logic [WR*AW-1:0] waddr,
  input  logic [WR*W-1:0]  wdata,
  input  logic [RD*AW-1:0] raddr,
  output logic [RD*W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    for (int i = 0; i < WR; i++)
      if (we[i]) mem[waddr[i*AW +: AW]] <= wdata[i*W +: W];
  always_comb
    for (int i = 0; i < RD; i++) rdata[i*W +: W] = mem[raddr[i*AW +: AW]];
endmodule

// File: rtl/fetch_queue_mw.sv
// fetch_queue_mw: multi-wide IF/ID fetch queue; CLK/RESET/FREEZE/flush, fetch_* push side with fetch_ready, issue_* pop side, occupancy, err_sticky
module fetch_queue_mw #(
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int DEPTH = 8,
  parameter int XLEN = 32,
  localparam int FCW = $clog2(FETCH_W+1),
  localparam int ICW = $clog2(ISSUE_W+1),
  localparam int AW = $clog2(DEPTH),
  localparam int OW = $clog2(DEPTH+1)
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    FREEZE,
  input  logic                    flush,
  input  logic                    fetch_valid,
  input  logic [FCW-1:0]          fetch_count,
  input  logic [FETCH_W*XLEN-1:0] fetch_instr,
  input  logic [XLEN-1:0]         fetch_pc,
  output logic                    fetch_ready,
  output logic [ICW-1:0]          issue_count,
  output logic [ISSUE_W*XLEN-1:0] issue_instr,
  output logic [ISSUE_W*XLEN-1:0] issue_pc,
  input  logic [ICW-1:0]          issue_take,
  output logic [OW-1:0]           occupancy,
  output logic                    err_sticky
);
  import fetch_queue_pkg::*;
  logic [AW-1:0] head, tail;
  logic [FETCH_W-1:0] we;
  logic [FETCH_W*AW-1:0] waddr;
  logic [FETCH_W*2*XLEN-1:0] wdata;
  logic [ISSUE_W*AW-1:0] raddr;
  logic [ISSUE_W*2*XLEN-1:0] rdata;
  logic bad_count, push, err_now;
  logic [FCW-1:0] push_n;
  logic [ICW-1:0] pop_n;
  assign fetch_ready = occupancy <= OW'(DEPTH - FETCH_W);
  assign issue_count = occupancy >= OW'(ISSUE_W) ? ICW'(ISSUE_W) : ICW'(occupancy);
  assign bad_count = fetch_count == '0 || fetch_count > FCW'(FETCH_W);
  assign push = fetch_valid && fetch_ready && !flush && !bad_count;
  assign push_n = push ? fetch_count : '0;
  assign pop_n = FREEZE ? '0 : ICW'(clamp_take(int'(issue_take), int'(issue_count)));
  assign err_now = !flush && ((fetch_valid && (!fetch_ready || bad_count)) || (!FREEZE && issue_take > issue_count));
  always_comb begin
    for (int i = 0; i < FETCH_W; i++) begin
      we[i] = push && FCW'(i) < fetch_count;
      waddr[i*AW +: AW] = tail + AW'(i);
      wdata[i*2*XLEN +: 2*XLEN] = {fetch_pc + XLEN'(INSTR_BYTES*i), fetch_instr[i*XLEN +: XLEN]};
    end
    for (int i = 0; i < ISSUE_W; i++) begin
      raddr[i*AW +: AW] = head + AW'(i);
      issue_instr[i*XLEN +: XLEN] = ICW'(i) < issue_count ? rdata[i*2*XLEN +: XLEN] : XLEN'(NOP_INSTR);
      issue_pc[i*XLEN +: XLEN] = ICW'(i) < issue_count ? rdata[i*2*XLEN+XLEN +: XLEN] : '0;
    end
  end
  fq_ring_ram #(.DEPTH(DEPTH), .WR(FETCH_W), .RD(ISSUE_W), .W(2*XLEN)) ram (
    .clk(CLK), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata)
  );
  always_ff @(posedge CLK) begin
    if (RESET || flush) begin
      head <= '0;
      tail <= '0;
      occupancy <= '0;
    end else begin
      head <= head + AW'(pop_n);
      tail <= tail + AW'(push_n);
      occupancy <= occupancy + OW'(push_n) - OW'(pop_n);
    end
    err_sticky <= RESET ? 1'b0 : err_sticky | err_now;
  end
endmodule

// File: tb/tb_fetch_queue_mw.sv
// tb_fetch_queue_mw: scoreboard bench comparing fetch_queue_mw against a queue-based reference model
module tb_fetch_queue_mw;
  localparam int FETCH_W = 2;
  localparam int ISSUE_W = 2;
  localparam int DEPTH = 8;
  localparam int XLEN = 32;
  localparam int FCW = $clog2(FETCH_W+1);
  localparam int ICW = $clog2(ISSUE_W+1);
  localparam int OW = $clog2(DEPTH+1);
  logic CLK = 0, RESET = 0, FREEZE = 0, flush = 0, fetch_valid = 0;
  logic [FCW-1:0] fetch_count = '0;
  logic [FETCH_W*XLEN-1:0] fetch_instr = '0;
  logic [XLEN-1:0] fetch_pc = '0;
  logic [ICW-1:0] issue_take = '0;
  logic fetch_ready, err_sticky;
  logic [ICW-1:0] issue_count;
  logic [ISSUE_W*XLEN-1:0] issue_instr, issue_pc;
  logic [OW-1:0] occupancy;
  fetch_queue_mw #(.FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .flush(flush), .fetch_valid(fetch_valid),
    .fetch_count(fetch_count), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready), .issue_count(issue_count), .issue_instr(issue_instr),
    .issue_pc(issue_pc), .issue_take(issue_take), .occupancy(occupancy), .err_sticky(err_sticky)
  );
  always #5 CLK = ~CLK;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
  ent_t exp_q[$];
  ent_t p_ent[$];
  bit exp_err = 0, mon_en = 0, p_rst = 0, p_err = 0;
  int nchk = 0, nerr = 0;
  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] want);
    nchk++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, want);
    end
  endfunction
  always @(negedge CLK) begin
    int sz, av, np;
    if (mon_en) begin
      sz = exp_q.size();
      av = sz < ISSUE_W ? sz : ISSUE_W;
      chk("occupancy", 64'(occupancy), 64'(sz));
      chk("fetch_ready", 64'(fetch_ready), 64'(sz <= DEPTH - FETCH_W));
      chk("issue_count", 64'(issue_count), 64'(av));
      chk("err_sticky", 64'(err_sticky), 64'(exp_err));
      for (int i = 0; i < ISSUE_W; i++) begin
        chk($sformatf("issue_instr[%0d]", i), 64'(issue_instr[i*XLEN +: XLEN]), i < av ? 64'(exp_q[i].instr) : 64'h0);
        chk($sformatf("issue_pc[%0d]", i), 64'(issue_pc[i*XLEN +: XLEN]), i < av ? 64'(exp_q[i].pc) : 64'h0);
      end
      if (RESET || flush) exp_q.delete();
      else if (!FREEZE) begin
        np = int'(issue_take) < av ? int'(issue_take) : av;
        repeat (np) void'(exp_q.pop_front());
      end
    end
  end
  task automatic step(input bit rst, input bit v, input int c, input int t, input bit frz, input bit fl,
                      input logic [31:0] pc, input logic [FETCH_W*XLEN-1:0] ins);
    int sz, av;
    bit rdy, bad;
    ent_t e;
    @(posedge CLK); #1;
    if (p_rst) begin
      exp_q.delete();
      exp_err = 0;
      mon_en = 1;
    end else begin
      foreach (p_ent[i]) exp_q.push_back(p_ent[i]);
      exp_err = exp_err | p_err;
    end
    p_ent.delete();
    RESET = rst; FREEZE = frz; flush = fl; fetch_valid = v;
    fetch_count = FCW'(c); issue_take = ICW'(t); fetch_pc = pc; fetch_instr = ins;
    sz = exp_q.size();
    av = sz < ISSUE_W ? sz : ISSUE_W;
    rdy = sz <= DEPTH - FETCH_W;
    bad = c == 0 || c > FETCH_W;
    if (v && rdy && !bad && !fl && !rst)
      for (int i = 0; i < c; i++) begin
        e.pc = pc + 32'(4*i);
        e.instr = ins[i*XLEN +: XLEN];
        p_ent.push_back(e);
      end
    p_err = !fl && !rst && ((v && (!rdy || bad)) || (!frz && t > av));
    p_rst = rst;
  endtask
  function automatic logic [FETCH_W*XLEN-1:0] rnd_ins();
    logic [FETCH_W*XLEN-1:0] r;
    for (int i = 0; i < FETCH_W; i++) r[i*XLEN +: XLEN] = $urandom;
    return r;
  endfunction
  task automatic idle(input int n);
    repeat (n) step(0, 0, 1, 0, 0, 0, 32'h0, '0);
  endtask
  task automatic do_reset();
    step(1, 0, 1, 0, 0, 0, 32'h0, '0);
    step(1, 0, 1, 0, 0, 0, 32'h0, '0);
  endtask
  initial begin
    logic [31:0] pc;
    int c;
    do_reset();
    idle(1);
    step(0, 1, 2, 0, 0, 0, 32'h400, {32'h00221820, 32'h8C010004});
    idle(2);
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 1, 2, 0, 0, 0, 32'h1000 + 32'(8*i), rnd_ins());
    idle(2);
    do_reset();
    step(0, 1, 2, 0, 0, 0, 32'h2000, rnd_ins());
    for (int i = 1; i <= 20; i++) step(0, 1, 2, 2, 0, 0, 32'h2000 + 32'(8*i), rnd_ins());
    idle(1);
    do_reset();
    step(0, 1, 2, 0, 0, 0, 32'h3000, rnd_ins());
    step(0, 1, 2, 0, 0, 0, 32'h3008, rnd_ins());
    step(0, 1, 1, 0, 0, 0, 32'h3010, rnd_ins());
    step(0, 1, 2, 2, 1, 0, 32'h3014, rnd_ins());
    idle(1);
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 2, 0, 0, 0, 32'h4000 + 32'(8*i), rnd_ins());
    step(0, 1, 2, 2, 0, 1, 32'h4018, rnd_ins());
    idle(2);
    do_reset();
    step(0, 1, 1, 0, 0, 0, 32'h5000, rnd_ins());
    step(0, 0, 1, 2, 0, 0, 32'h0, '0);
    idle(1);
    do_reset();
    idle(1);
    pc = 32'h8000;
    for (int n = 0; n < 600; n++) begin
      c = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 3) : $urandom_range(1, FETCH_W);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, c, $urandom_range(0, 3),
           $urandom_range(0, 6) == 0, $urandom_range(0, 19) == 0, pc, rnd_ins());
      pc = pc + 32'(4*FETCH_W);
    end
    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
